// File: rtl/exec_stage_md.sv
// exec_stage_md: MIPS execute stage with registered outputs, valid/ready and iterative mult/div (HI/LO).
// Define EXEC_FAST_MUL_EN for a single-cycle combinational mult/multu; divide stays iterative.
module exec_stage_md #(
    parameter int WIDTH = 32,
    parameter int MD_EN = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [WIDTH-1:0]         rs_data_i,
    input  logic [WIDTH-1:0]         rt_data_i,
    input  logic [WIDTH-1:0]         fwd_ex_i,
    input  logic [WIDTH-1:0]         fwd_wb_i,
    input  logic [1:0]               fwd_a_sel_i,
    input  logic [1:0]               fwd_b_sel_i,
    input  logic [WIDTH-1:0]         imm_i,
    input  logic                     alusrc_i,
    input  logic [$clog2(WIDTH)-1:0] shamt_i,
    input  logic [3:0]               alu_ctrl_i,
    input  logic [2:0]               md_op_i,
    input  logic [4:0]               rt_i,
    input  logic [4:0]               rd_i,
    input  logic                     regdst_i,
    input  logic [WIDTH-1:0]         pc_plus4_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         result_o,
    output logic                     zero_o,
    output logic                     ovf_o,
    output logic [4:0]               dst_o,
    output logic [WIDTH-1:0]         branch_tgt_o,
    output logic                     md_done_o
);
    localparam int SW = $clog2(WIDTH);
`ifdef EXEC_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    logic [WIDTH-1:0] hi, lo, a, b, fb, alu, res, sum, diff, am, bm, mc, a_raw, b_raw, acc_hi, acc_lo, nh, nl, qf, rf;
    logic [WIDTH:0] madd, sh, dsub;
    logic [2*WIDTH-1:0] prod, fprod;
    logic [SW-1:0] cnt;
    logic busy, is_div, sgn, fast, neg_q, neg_r, dz, ovf, ge, acc, is_md, alu_path, sgn_op, an, bn;

    assign ready_o  = !busy;
    assign acc      = valid_i && ready_o;
    assign is_md    = (MD_EN != 0) && md_op_i >= 3'd1 && md_op_i <= 3'd4;
    assign alu_path = md_op_i == 3'd0 || md_op_i == 3'd7;
    assign a  = fwd_a_sel_i == 2'd0 ? rs_data_i : fwd_a_sel_i == 2'd1 ? fwd_ex_i : fwd_a_sel_i == 2'd2 ? fwd_wb_i : '0;
    assign fb = fwd_b_sel_i == 2'd0 ? rt_data_i : fwd_b_sel_i == 2'd1 ? fwd_ex_i : fwd_b_sel_i == 2'd2 ? fwd_wb_i : '0;
    assign b  = alusrc_i ? imm_i : fb;
    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        alu = '0;
        ovf = 1'b0;
        case (alu_ctrl_i)
            4'd0:  alu = a & b;
            4'd1:  alu = a | b;
            4'd2:  begin alu = sum;  ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]); end
            4'd3:  alu = b << shamt_i;
            4'd4:  alu = b >> shamt_i;
            4'd5:  alu = $signed(b) >>> shamt_i;
            4'd6:  begin alu = diff; ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]); end
            4'd7:  alu = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'd8:  alu = {{(WIDTH-1){1'b0}}, a < b};
            4'd9:  alu = a ^ b;
            4'd12: alu = ~(a | b);
            default: alu = '0;
        endcase
    end

    assign res = md_op_i == 3'd5 ? hi : md_op_i == 3'd6 ? lo : alu_path ? alu : '0;

    // Iterative unit works on magnitudes; signs are restored when HI/LO are written.
    assign sgn_op = md_op_i == 3'd1 || md_op_i == 3'd3;
    assign an = sgn_op && a[WIDTH-1];
    assign bn = sgn_op && b[WIDTH-1];
    assign am = an ? -a : a;
    assign bm = bn ? -b : b;

    // Divide borrow comes from dsub's top bit: valid while remainder < divisor, and a
    // zero divisor is overridden at the end anyway.
    assign madd = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mc} : '0);
    assign sh   = {acc_hi, acc_lo[WIDTH-1]};
    assign dsub = sh - {1'b0, mc};
    assign ge   = !dsub[WIDTH];
    assign nh   = is_div ? (ge ? dsub[WIDTH-1:0] : sh[WIDTH-1:0]) : madd[WIDTH:1];
    assign nl   = is_div ? {acc_lo[WIDTH-2:0], ge} : {madd[0], acc_lo[WIDTH-1:1]};
    assign prod  = neg_q ? -{nh, nl} : {nh, nl};
    assign qf    = dz ? '1 : neg_q ? -nl : nl;
    assign rf    = dz ? a_raw : neg_r ? -nh : nh;
    assign fprod = {{WIDTH{sgn & a_raw[WIDTH-1]}}, a_raw} * {{WIDTH{sgn & b_raw[WIDTH-1]}}, b_raw};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            result_o <= '0;
            zero_o <= 1'b0;
            ovf_o <= 1'b0;
            dst_o <= '0;
            branch_tgt_o <= '0;
            md_done_o <= 1'b0;
            hi <= '0;
            lo <= '0;
            busy <= 1'b0;
            cnt <= '0;
            is_div <= 1'b0;
            sgn <= 1'b0;
            fast <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz <= 1'b0;
            a_raw <= '0;
            b_raw <= '0;
            mc <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else begin
            valid_o <= acc && !is_md;
            md_done_o <= 1'b0;
            if (acc && !is_md) begin
                result_o <= res;
                zero_o <= res == '0;
                ovf_o <= alu_path && ovf;
                dst_o <= regdst_i ? rd_i : rt_i;
                branch_tgt_o <= pc_plus4_i + (imm_i << 2);
            end
            if (acc && is_md) begin
                busy <= 1'b1;
                cnt <= '0;
                is_div <= md_op_i >= 3'd3;
                sgn <= sgn_op;
                fast <= FAST && md_op_i <= 3'd2;
                neg_q <= an ^ bn;
                neg_r <= an;
                dz <= b == '0;
                a_raw <= a;
                b_raw <= b;
                mc <= bm;
                acc_hi <= '0;
                acc_lo <= am;
            end
            if (busy) begin
                acc_hi <= nh;
                acc_lo <= nl;
                cnt <= cnt + SW'(1);
                if (fast || cnt == SW'(WIDTH - 1)) begin
                    busy <= 1'b0;
                    md_done_o <= 1'b1;
                    {hi, lo} <= fast ? fprod : is_div ? {rf, qf} : prod;
                end
            end
        end
    end
endmodule

// File: tb/tb_exec_stage_md.sv
// tb_exec_stage_md: random + directed bench for exec_stage_md against a cycle-level behavioural model.
module tb_exec_stage_md;
`ifdef EXEC_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_i, valid_i, ready_o, alusrc_i, regdst_i, valid_o, zero_o, ovf_o, md_done_o;
    logic [31:0] rs_data_i, rt_data_i, fwd_ex_i, fwd_wb_i, imm_i, pc_plus4_i, result_o, branch_tgt_o;
    logic [1:0] fwd_a_sel_i, fwd_b_sel_i;
    logic [4:0] shamt_i, rt_i, rd_i, dst_o;
    logic [3:0] alu_ctrl_i;
    logic [2:0] md_op_i;
    int checks = 0;
    int errors = 0;

    // expected state
    logic m_valid, m_zero, m_ovf, m_done;
    logic [31:0] m_res, m_bt, m_hi, m_lo, p_hi, p_lo;
    logic [4:0] m_dst;
    int m_left;

    exec_stage_md #(.WIDTH(32), .MD_EN(1)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .fwd_ex_i(fwd_ex_i), .fwd_wb_i(fwd_wb_i),
        .fwd_a_sel_i(fwd_a_sel_i), .fwd_b_sel_i(fwd_b_sel_i), .imm_i(imm_i), .alusrc_i(alusrc_i),
        .shamt_i(shamt_i), .alu_ctrl_i(alu_ctrl_i), .md_op_i(md_op_i), .rt_i(rt_i), .rd_i(rd_i),
        .regdst_i(regdst_i), .pc_plus4_i(pc_plus4_i), .valid_o(valid_o), .result_o(result_o),
        .zero_o(zero_o), .ovf_o(ovf_o), .dst_o(dst_o), .branch_tgt_o(branch_tgt_o), .md_done_o(md_done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] opnd(logic [1:0] s, logic [31:0] r);
        return s == 2'd0 ? r : s == 2'd1 ? fwd_ex_i : s == 2'd2 ? fwd_wb_i : 32'd0;
    endfunction

    task automatic alu_calc(logic [3:0] c, logic [31:0] a, logic [31:0] b, output logic [31:0] r, output logic o);
        longint s;
        r = 32'd0;
        o = 1'b0;
        case (c)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd9: r = a ^ b;
            4'd12: r = ~(a | b);
            4'd2, 4'd6: begin
                s = c == 4'd2 ? longint'($signed(a)) + longint'($signed(b)) : longint'($signed(a)) - longint'($signed(b));
                r = s[31:0];
                o = s != longint'($signed(r));
            end
            4'd7: r = $signed(a) < $signed(b) ? 32'd1 : 32'd0;
            4'd8: r = a < b ? 32'd1 : 32'd0;
            4'd3: r = b << shamt_i;
            4'd4: r = b >> shamt_i;
            4'd5: r = $signed(b) >>> shamt_i;
            default: r = 32'd0;
        endcase
    endtask

    task automatic md_calc(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint p;
        logic [63:0] pu;
        int sa, sb;
        sa = a;
        sb = b;
        if (op == 3'd1) begin
            p = longint'(sa) * longint'(sb);
            p_hi = p[63:32];
            p_lo = p[31:0];
        end else if (op == 3'd2) begin
            pu = {32'd0, a} * {32'd0, b};
            p_hi = pu[63:32];
            p_lo = pu[31:0];
        end else if (b == 32'd0) begin
            p_lo = 32'hFFFF_FFFF;
            p_hi = a;
        end else if (op == 3'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            p_lo = 32'h8000_0000;
            p_hi = 32'd0;
        end else if (op == 3'd3) begin
            p_lo = sa / sb;
            p_hi = sa % sb;
        end else begin
            p_lo = a / b;
            p_hi = a % b;
        end
    endtask

    task automatic model_update();
        logic [31:0] a, b, r;
        logic o;
        if (rst_i) begin
            m_valid = 0; m_res = 0; m_zero = 0; m_ovf = 0; m_dst = 0; m_bt = 0;
            m_hi = 0; m_lo = 0; m_left = 0; m_done = 0;
            return;
        end
        m_valid = 0;
        m_done = 0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
                m_done = 1;
            end
        end else if (valid_i) begin
            a = opnd(fwd_a_sel_i, rs_data_i);
            b = alusrc_i ? imm_i : opnd(fwd_b_sel_i, rt_data_i);
            if (md_op_i >= 3'd1 && md_op_i <= 3'd4) begin
                md_calc(md_op_i, a, b);
                m_left = (FAST && md_op_i <= 3'd2) ? 1 : 32;
            end else begin
                o = 1'b0;
                if (md_op_i == 3'd5) r = m_hi;
                else if (md_op_i == 3'd6) r = m_lo;
                else alu_calc(alu_ctrl_i, a, b, r, o);
                m_valid = 1;
                m_res = r;
                m_zero = r == 32'd0;
                m_ovf = o;
                m_dst = regdst_i ? rd_i : rt_i;
                m_bt = pc_plus4_i + imm_i * 4;
            end
        end
    endtask

    task automatic compare();
        chk("valid_o", 32'(valid_o), 32'(m_valid));
        chk("ready_o", 32'(ready_o), m_left == 0 ? 32'd1 : 32'd0);
        chk("md_done_o", 32'(md_done_o), 32'(m_done));
        if (m_valid) begin
            chk("result_o", result_o, m_res);
            chk("zero_o", 32'(zero_o), 32'(m_zero));
            chk("ovf_o", 32'(ovf_o), 32'(m_ovf));
            chk("dst_o", 32'(dst_o), 32'(m_dst));
            chk("branch_tgt_o", branch_tgt_o, m_bt);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic set_nop();
        valid_i = 0; rs_data_i = 0; rt_data_i = 0; fwd_ex_i = 0; fwd_wb_i = 0;
        fwd_a_sel_i = 0; fwd_b_sel_i = 0; imm_i = 0; alusrc_i = 0; shamt_i = 0;
        alu_ctrl_i = 0; md_op_i = 0; rt_i = 0; rd_i = 0; regdst_i = 0; pc_plus4_i = 0;
    endtask

    function automatic logic [31:0] rval();
        int k = $urandom_range(0, 7);
        return k == 0 ? 32'd0 : k == 1 ? 32'h8000_0000 : k == 2 ? 32'hFFFF_FFFF :
               k == 3 ? 32'h7FFF_FFFF : k == 4 ? 32'($urandom_range(0, 15)) : 32'($urandom);
    endfunction

    task automatic rand_inputs();
        int k;
        rst_i = $urandom_range(0, 299) == 0;
        valid_i = $urandom_range(0, 3) != 0;
        rs_data_i = rval(); rt_data_i = rval(); fwd_ex_i = rval(); fwd_wb_i = rval();
        imm_i = rval(); pc_plus4_i = 32'($urandom);
        fwd_a_sel_i = 2'($urandom); fwd_b_sel_i = 2'($urandom);
        alusrc_i = 1'($urandom); regdst_i = 1'($urandom);
        shamt_i = 5'($urandom); alu_ctrl_i = 4'($urandom);
        rt_i = 5'($urandom); rd_i = 5'($urandom);
        k = $urandom_range(0, 99);
        md_op_i = k < 4 ? 3'($urandom_range(1, 4)) : k < 14 ? 3'($urandom_range(5, 6)) : 3'd0;
    endtask

    // Issue one mult/div, hold mfhi on the inputs while busy, then read HI and LO.
    task automatic do_md(string nm, logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] eh, logic [31:0] el);
        int n = 0;
        set_nop();
        valid_i = 1; md_op_i = op; rs_data_i = a; rt_data_i = b;
        step();
        md_op_i = 3'd5;
        while (ready_o === 1'b0 && n < 40) begin
            n++;
            step();
        end
        chk({nm, " busy cycles"}, 32'(n), (FAST && op <= 3'd2) ? 32'd1 : 32'd32);
        chk({nm, " md_done"}, 32'(md_done_o), 32'd1);
        step();
        chk({nm, " hi"}, result_o, eh);
        md_op_i = 3'd6;
        step();
        chk({nm, " lo"}, result_o, el);
        valid_i = 0;
        step();
    endtask

    initial begin
        int pulses;
        set_nop();
        rst_i = 1;
        repeat (3) step();
        chk("rst ready", 32'(ready_o), 32'd1);
        chk("rst valid", 32'(valid_o), 32'd0);
        chk("rst result", result_o, 32'd0);
        chk("rst bt", branch_tgt_o, 32'd0);
        rst_i = 0;

        valid_i = 1; rs_data_i = 32'h7FFF_FFFF; rt_data_i = 32'd1; alu_ctrl_i = 4'd2;
        step();
        chk("add result", result_o, 32'h8000_0000);
        chk("add ovf", 32'(ovf_o), 32'd1);
        chk("add zero", 32'(zero_o), 32'd0);
        valid_i = 0;
        step();
        chk("hold result", result_o, 32'h8000_0000);

        set_nop();
        valid_i = 1; fwd_a_sel_i = 2'd1; fwd_ex_i = 32'd5; alusrc_i = 1; imm_i = 32'd5;
        regdst_i = 1; rd_i = 5'd9; rt_i = 5'd3; alu_ctrl_i = 4'd6;
        step();
        chk("sub zero", 32'(zero_o), 32'd1);
        chk("sub dst", 32'(dst_o), 32'd9);
        pc_plus4_i = 32'h100; imm_i = 32'hFFFF_FFFF;
        step();
        chk("branch tgt", branch_tgt_o, 32'hFC);
        valid_i = 0;
        step();

        do_md("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        do_md("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        do_md("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_md("divu0", 3'd4, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        do_md("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

        set_nop();
        valid_i = 1; md_op_i = 3'd3; rs_data_i = 32'd100; rt_data_i = 32'd7;
        step();
        valid_i = 0;
        repeat (10) step();
        rst_i = 1;
        step();
        rst_i = 0;
        chk("abort ready", 32'(ready_o), 32'd1);
        valid_i = 1; md_op_i = 3'd5;
        step();
        chk("abort hi", result_o, 32'd0);
        md_op_i = 3'd6;
        step();
        chk("abort lo", result_o, 32'd0);
        valid_i = 0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            pulses += md_done_o ? 1 : 0;
        end
        chk("abort no done", 32'(pulses), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
